arm_instr_encoder: RTL
======================

Name: arm_instr_encoder

Overview:
Sequential encoder that turns field-level instruction requests into 32-bit ARM machine words that the single-cycle decoder's main/ALU decoder consumes. It covers exactly the decoder's instruction set: ADD, SUB, AND, ORR, CMP (immediate or register), LDR/STR (immediate offset) and B.
It sits between the Donkey Kong program loader/test sequencer and the instruction-memory write port. Each accepted word is tagged with a sequential instruction-memory address.
DP immediates are rotation-encoded by a multi-cycle search.

Parameters:
ADDR_W, 6, instruction-memory word-address width (capacity 2**ADDR_W words)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
req_valid  in  1  request valid
req_ready  out  1  encoder can accept a request
req_op  in  3  enc_pkg::op_t: ADD=0, SUB=1, AND=2, ORR=3, CMP=4, LDR=5, STR=6, B=7
req_cond  in  4  condition field
req_s  in  1  S bit (DP only; CMP forces 1)
req_rd  in  4  destination / LDR-STR data register
req_rn  in  4  first source / base register
req_rm  in  4  register operand2
req_use_imm  in  1  DP: immediate operand2 when 1
req_imm  in  32  DP immediate value, LDR/STR offset, or B word offset (signed)
out_valid  out  1  encoded word valid
out_ready  in  1  consumer accepts word
out_instr  out  32  encoded instruction
out_addr  out  ADDR_W  word address for out_instr
out_err  out  1  request was unencodable (out_instr = 0)
full  out  1  all 2**ADDR_W addresses consumed

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE, req_ready=1, out_valid=0, out_instr=0, out_addr=0, out_err=0, full=0, word counter=0. Reset mid-search or mid-HOLD drops the request.
- FSM has three states: IDLE, ROTATE, HOLD.
- IDLE:
  - req_ready = !full.
  - Accept on req_valid & req_ready and latch all fields.
  - DP with use_imm and imm[31:8]==0: go to HOLD with rot=0.
  - DP with use_imm otherwise: go to ROTATE with r=1.
  - All other requests: go to HOLD.
- ROTATE: req_ready=0. Each cycle test whether ROL(imm, 2r)[31:8]==0.
  - Hit: rot=r, imm8=ROL(imm,2r)[7:0], go to HOLD.
  - Miss with r<15: increment r.
  - Miss at r=15: go to HOLD with err=1.
  - Smallest r wins.
- Latency: out_valid rises 1 cycle after accept for direct cases and 1+r cycles for rotated immediates. An unencodable immediate gives 16 cycles.
- HOLD: out_valid=1; out_instr, out_addr and out_err stay stable until out_ready.
  - On handshake: return to IDLE.
  - If err==0, the counter increments. Error words do not consume an address.
  - full=1 when counter==2**ADDR_W. The counter saturates there. out_addr = counter[ADDR_W-1:0].
- DP encoding:
  - [31:28]=cond, [27:26]=00, [25]=use_imm.
  - [24:21]=cmd: ADD 0100, SUB 0010, AND 0000, ORR 1100, CMP 1010.
  - [20]=S (1 for CMP), [19:16]=Rn, [15:12]=Rd (0 for CMP).
  - [11:0] = {rot, imm8} for immediates, or {8'b0, Rm} for registers.
- LDR/STR encoding: cond, 01, [25:20]=011001 (LDR) or 011000 (STR), Rn, Rd, imm[11:0]. err if imm[31:12]!=0.
- B encoding: cond, 1010, imm[23:0]. err if imm[31:24] is not the sign-extension of imm[23].
- While full: req_ready=0; requests are held off, not dropped.

Optional Feature:
ENC_ERR_CNT_EN
- Defined: adds output err_count (8 bits). It increments on each err handshake, saturates at 255, and resets to 0.
- Undefined: the port and its logic are absent.

Decomposition:
- enc_pkg: op_t enum, DP cmd constants (CMD_ADD/SUB/AND/ORR/CMP), MEM_FUNCT_LDR/STR, COND_AL=4'hE, state_t.
- One sub-module, rot_imm_check: combinational; inputs imm and r, outputs hit and imm8. It is instantiated once inside the ROTATE datapath.

Test Plan:
- ADD cond=E, rd=1, rn=2, imm=5, use_imm=1, S=0, out_ready=1 -> out_instr=32'hE2821005, out_addr=0, out_valid 1 cycle after accept.
- ORR rd=0, rn=0, imm=32'hFF000000 -> 32'hE38004FF, valid 5 cycles after accept. Then imm=32'h00000101 -> out_err=1, out_instr=0 after 16 cycles, next out_addr unchanged.
- LDR rd=3, rn=4, imm=8 -> 32'hE5943008. STR same fields -> 32'hE5843008. LDR imm=32'h1000 -> out_err=1.
- CMP register rn=1, rm=2, S=0 -> 32'hE1510002. B imm=32'hFFFFFFFE -> 32'hEAFFFFFE.
- out_ready held low for 10 cycles in HOLD -> out_instr/out_addr stable and req_ready=0; release -> single handshake, addr increments by 1.
- ADDR_W=2: 4 valid words -> full=1, req_ready=0 with req_valid held. Pulse reset low mid-ROTATE -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/arm_instr_encoder_pkg.sv
// enc_pkg: shared types and encoding helpers for arm_instr_encoder.
//   op_t         request opcode (ADD=0 .. B=7)
//   state_t      encoder FSM states
//   enc_word_t   {err, instr} result of an encoding attempt
//   encode_word  builds the 32-bit machine word from fields (instr forced to 0 on error)
package enc_pkg;

    typedef enum logic [2:0] {
        OpAdd = 3'd0,
        OpSub = 3'd1,
        OpAnd = 3'd2,
        OpOrr = 3'd3,
        OpCmp = 3'd4,
        OpLdr = 3'd5,
        OpStr = 3'd6,
        OpB   = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        StIdle,
        StRotate,
        StHold
    } state_t;

    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } enc_word_t;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [5:0] MEM_FUNCT_LDR = 6'b011001;
    localparam logic [5:0] MEM_FUNCT_STR = 6'b011000;

    localparam logic [3:0] COND_AL = 4'hE;

    function automatic logic is_dp(input op_t op);
        return (op == OpAdd) || (op == OpSub) || (op == OpAnd) ||
               (op == OpOrr) || (op == OpCmp);
    endfunction

    // For DP immediates the caller supplies the already-found rot/imm8 pair.
    function automatic enc_word_t encode_word(
        input op_t         op,
        input logic [3:0]  cond,
        input logic        s,
        input logic [3:0]  rd,
        input logic [3:0]  rn,
        input logic [3:0]  rm,
        input logic        use_imm,
        input logic [31:0] imm,
        input logic [3:0]  rot,
        input logic [7:0]  imm8
    );
        enc_word_t  res;
        logic [3:0] cmd;
        logic       s_bit;
        logic [3:0] rd_f;
        logic [11:0] op2;
        res.err   = 1'b0;
        res.instr = 32'h0;
        cmd       = CMD_AND;
        s_bit     = s;
        rd_f      = rd;
        op2       = use_imm ? {rot, imm8} : {8'h00, rm};
        unique case (op)
            OpAdd: cmd = CMD_ADD;
            OpSub: cmd = CMD_SUB;
            OpAnd: cmd = CMD_AND;
            OpOrr: cmd = CMD_ORR;
            OpCmp: begin
                cmd   = CMD_CMP;
                s_bit = 1'b1;
                rd_f  = 4'h0;
            end
            default: cmd = CMD_AND;
        endcase
        unique case (op)
            OpLdr, OpStr: begin
                if (imm[31:12] != 20'h0) begin
                    res.err = 1'b1;
                end else begin
                    res.instr = {cond, 2'b01,
                                 (op == OpLdr) ? MEM_FUNCT_LDR : MEM_FUNCT_STR,
                                 rn, rd, imm[11:0]};
                end
            end
            OpB: begin
                // Offset must fit a signed 24-bit field.
                if (imm[31:24] != {8{imm[23]}}) begin
                    res.err = 1'b1;
                end else begin
                    res.instr = {cond, 4'b1010, imm[23:0]};
                end
            end
            default: begin
                res.instr = {cond, 2'b00, use_imm, cmd, s_bit, rn, rd_f, op2};
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/arm_instr_encoder_rot_imm_check.sv
// rot_imm_check: tests one rotation candidate for a DP immediate.
//   imm   in   32-bit immediate to encode
//   r     in   rotation candidate (the word is rotated left by 2*r)
//   hit   out  rotated value fits in 8 bits
//   imm8  out  low byte of the rotated value
module rot_imm_check (
    input  logic [31:0] imm,
    input  logic [3:0]  r,
    output logic        hit,
    output logic [7:0]  imm8
);

    logic [4:0]  sh;
    logic [31:0] rol;

    assign sh = {r, 1'b0};
    // A right shift by 32 (r == 0) yields zero, so the rotate stays correct.
    assign rol  = (imm << sh) | (imm >> (6'd32 - {1'b0, sh}));
    assign hit  = (rol[31:8] == 24'h0);
    assign imm8 = rol[7:0];

endmodule

// File: rtl/arm_instr_encoder.sv
// arm_instr_encoder: turns field-level instruction requests into 32-bit ARM words
// tagged with sequential instruction-memory addresses.
//   clk, reset           clock, synchronous active-low reset
//   req_*                request handshake and instruction fields
//   out_valid/out_ready  output handshake; out_instr/out_addr/out_err held until accepted
//   full                 every address of the 2**ADDR_W word memory has been used
// Optional build macro ENC_ERR_CNT_EN adds err_count, a saturating count of error words.
module arm_instr_encoder
    import enc_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  op_t               req_op,
    input  logic [3:0]        req_cond,
    input  logic              req_s,
    input  logic [3:0]        req_rd,
    input  logic [3:0]        req_rn,
    input  logic [3:0]        req_rm,
    input  logic              req_use_imm,
    input  logic [31:0]       req_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              full
`ifdef ENC_ERR_CNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    state_t      state_q, state_d;
    logic [3:0]  r_q, r_d;
    op_t         op_q, op_d;
    logic [3:0]  cond_q, cond_d;
    logic        s_q, s_d;
    logic [3:0]  rd_q, rd_d;
    logic [3:0]  rn_q, rn_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
`ifdef ENC_ERR_CNT_EN
    logic [7:0]  err_cnt_q, err_cnt_d;
`endif

    logic        rot_hit;
    logic [7:0]  rot_imm8;
    enc_word_t   enc_idle;
    enc_word_t   enc_rot;
    logic        accept;
    logic        needs_rot;

    rot_imm_check u_rot_imm_check (
        .imm  (imm_q),
        .r    (r_q),
        .hit  (rot_hit),
        .imm8 (rot_imm8)
    );

    // Direct path: everything except DP immediates wider than 8 bits.
    assign enc_idle = encode_word(req_op, req_cond, req_s, req_rd, req_rn, req_rm,
                                  req_use_imm, req_imm, 4'h0, req_imm[7:0]);
    // Rotate path: only DP immediates reach ROTATE, so use_imm is implied.
    assign enc_rot  = encode_word(op_q, cond_q, s_q, rd_q, rn_q, 4'h0,
                                  1'b1, imm_q, r_q, rot_imm8);

    assign full      = (cnt_q == {1'b1, {ADDR_W{1'b0}}});
    assign req_ready = (state_q == StIdle) && !full;
    assign accept    = req_valid && req_ready;
    assign needs_rot = is_dp(req_op) && req_use_imm && (req_imm[31:8] != 24'h0);

    assign out_valid = (state_q == StHold);
    assign out_instr = instr_q;
    assign out_err   = err_q;
    assign out_addr  = cnt_q[ADDR_W-1:0];
`ifdef ENC_ERR_CNT_EN
    assign err_count = err_cnt_q;
`endif

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        op_d    = op_q;
        cond_d  = cond_q;
        s_d     = s_q;
        rd_d    = rd_q;
        rn_d    = rn_q;
        imm_d   = imm_q;
        instr_d = instr_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
`ifdef ENC_ERR_CNT_EN
        err_cnt_d = err_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d   = req_op;
                    cond_d = req_cond;
                    s_d    = req_s;
                    rd_d   = req_rd;
                    rn_d   = req_rn;
                    imm_d  = req_imm;
                    if (needs_rot) begin
                        r_d     = 4'd1;
                        state_d = StRotate;
                    end else begin
                        instr_d = enc_idle.instr;
                        err_d   = enc_idle.err;
                        state_d = StHold;
                    end
                end
            end
            StRotate: begin
                if (rot_hit) begin
                    instr_d = enc_rot.instr;
                    err_d   = 1'b0;
                    state_d = StHold;
                end else if (r_q == 4'd15) begin
                    instr_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = StHold;
                end else begin
                    r_d = r_q + 4'd1;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                    // Error words do not consume an address.
                    if (!err_q && !full) begin
                        cnt_d = cnt_q + 1'b1;
                    end
`ifdef ENC_ERR_CNT_EN
                    if (err_q && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            r_q     <= 4'd0;
            op_q    <= OpAdd;
            cond_q  <= 4'h0;
            s_q     <= 1'b0;
            rd_q    <= 4'h0;
            rn_q    <= 4'h0;
            imm_q   <= 32'h0;
            instr_q <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef ENC_ERR_CNT_EN
            err_cnt_q <= 8'h0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            op_q    <= op_d;
            cond_q  <= cond_d;
            s_q     <= s_d;
            rd_q    <= rd_d;
            rn_q    <= rn_d;
            imm_q   <= imm_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`ifdef ENC_ERR_CNT_EN
            err_cnt_q <= err_cnt_d;
`endif
        end
    end

endmodule
